// File: rtl/gcd_dispatcher.sv
// gcd_dispatcher: buffers operand pairs in a small FIFO and drives one job at a
// time through an external GCD core using its start/done handshake, then
// presents operands plus result on a valid/ready output.
// Optional feature macro: GCD_DISP_TIMEOUT_EN (abort a job after TIMEOUT cycles
// in WAIT_DONE, reported through out_err).
`timescale 1ns/1ps

module gcd_dispatcher #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [WIDTH-1:0] out_gcd,
    output logic             out_err,
    output logic             gcd_start,
    output logic [WIDTH-1:0] gcd_a,
    output logic [WIDTH-1:0] gcd_b,
    input  logic             gcd_done,
    input  logic [WIDTH-1:0] gcd_result,
    output logic             busy,
    output logic [15:0]      jobs_done
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    // Parameter sanity checks at elaboration
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("gcd_dispatcher: DEPTH must be a power of 2 and at least 2");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("gcd_dispatcher: TIMEOUT must be at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_DONE = 3'd2,
        S_WAIT_CLR  = 3'd3,
        S_OUTPUT    = 3'd4
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] mem_a [DEPTH];
    logic [WIDTH-1:0] mem_b [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;

    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             capture;
    logic             expire;
    logic             finish;

    // A push is only taken when not full, regardless of a same-cycle pop
    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign in_ready = !full;
    assign push     = in_valid && !full;

`ifdef GCD_DISP_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_cnt;

    // Cycles spent in WAIT_DONE; zero in every other state so each entry starts fresh
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (state == S_WAIT_DONE) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end else begin
            tmo_cnt <= '0;
        end
    end
`endif

    // Next-state and per-cycle control strobes
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        capture   = 1'b0;
        expire    = 1'b0;
        finish    = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_nxt = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (gcd_done) begin
                    capture   = 1'b1;
                    state_nxt = S_WAIT_CLR;
                end
`ifdef GCD_DISP_TIMEOUT_EN
                else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
                    expire    = 1'b1;
                    state_nxt = S_OUTPUT;
                end
`endif
            end
            S_WAIT_CLR: begin
                if (!gcd_done) begin
                    state_nxt = S_OUTPUT;
                end
            end
            S_OUTPUT: begin
                if (out_ready) begin
                    finish    = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // FIFO occupancy after this cycle's push/pop
    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + CNT_W'(1);
        end else if (!push && pop) begin
            count_nxt = count - CNT_W'(1);
        end
    end

    // State register plus registered status/strobe outputs decoded from next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            gcd_start <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            gcd_start <= (state_nxt == S_ISSUE);
            out_valid <= (state_nxt == S_OUTPUT);
            busy      <= (state_nxt != S_IDLE) || (count_nxt != '0);
        end
    end

    // FIFO storage (no reset needed; occupancy is tracked separately)
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr] <= in_a;
            mem_b[wr_ptr] <= in_b;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_nxt;
        end
    end

    // Job datapath: operands latched at pop, result at first done, hand-off counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gcd_a     <= '0;
            gcd_b     <= '0;
            out_a     <= '0;
            out_b     <= '0;
            out_gcd   <= '0;
            jobs_done <= '0;
        end else begin
            if (pop) begin
                gcd_a <= mem_a[rd_ptr];
                gcd_b <= mem_b[rd_ptr];
                out_a <= mem_a[rd_ptr];
                out_b <= mem_b[rd_ptr];
            end
            if (capture) begin
                out_gcd <= gcd_result;
            end else if (expire) begin
                out_gcd <= '0;
            end
            if (finish) begin
                jobs_done <= jobs_done + 16'd1;
            end
        end
    end

`ifdef GCD_DISP_TIMEOUT_EN
    // Error flag: set by an abort, cleared by the next real completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_err <= 1'b0;
        end else if (capture) begin
            out_err <= 1'b0;
        end else if (expire) begin
            out_err <= 1'b1;
        end
    end
`else
    assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_gcd_dispatcher.sv
// Scoreboard bench for gcd_dispatcher with a behavioural GCD core stub.
// Expected results come from a Euclid reference; a monitor pops and compares.
`timescale 1ns/1ps

module tb_gcd_dispatcher;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] g;
        logic        err;
    } job_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_a;
    logic [15:0] out_b;
    logic [15:0] out_gcd;
    logic        out_err;
    logic        gcd_start;
    logic [15:0] gcd_a;
    logic [15:0] gcd_b;
    logic        gcd_done;
    logic [15:0] gcd_result;
    logic        busy;
    logic [15:0] jobs_done;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   n_starts = 0;
    int   exp_jobs = 0;
    int   rdy_mode = 0;
    int   lat_max = 3;
    logic core_hold = 1'b0;
    logic core_kill = 1'b0;

    job_t sb_q[$];
    job_t iss_q[$];

    gcd_dispatcher #(.WIDTH(16), .DEPTH(4), .TIMEOUT(1024)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_gcd(out_gcd), .out_err(out_err),
        .gcd_start(gcd_start), .gcd_a(gcd_a), .gcd_b(gcd_b),
        .gcd_done(gcd_done), .gcd_result(gcd_result),
        .busy(busy), .jobs_done(jobs_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] ref_gcd(input logic [15:0] a, input logic [15:0] b);
        int unsigned x = a;
        int unsigned y = b;
        int unsigned t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return 16'(x);
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Behavioural GCD core: latency then done held high for 1..3 cycles
    logic [15:0] st_res;
    int          st_lat;
    int          st_hi;
    logic        st_run;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_run     <= 1'b0;
            st_lat     <= 0;
            st_hi      <= 0;
            st_res     <= '0;
            gcd_done   <= 1'b0;
            gcd_result <= '0;
        end else if (core_kill) begin
            st_run   <= 1'b0;
            gcd_done <= 1'b0;
        end else if (gcd_start) begin
            st_run   <= 1'b1;
            st_res   <= ref_gcd(gcd_a, gcd_b);
            st_lat   <= int'($urandom_range(0, lat_max));
            st_hi    <= int'($urandom_range(1, 3));
            gcd_done <= 1'b0;
        end else if (st_run && !core_hold) begin
            if (st_lat > 0) begin
                st_lat <= st_lat - 1;
            end else if (st_hi > 0) begin
                gcd_done   <= 1'b1;
                gcd_result <= st_res;
                st_hi      <= st_hi - 1;
            end else begin
                gcd_done   <= 1'b0;
                gcd_result <= 16'($urandom);
                st_run     <= 1'b0;
            end
        end
    end

    // Consumer ready pattern
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    // Monitor: issue order, start/done overlap, output stability, scoreboard
    logic hold_prev = 1'b0;
    job_t held;
    always @(negedge clk) begin
        job_t e;
        if (rst_n) begin
            if (gcd_start) begin
                n_starts++;
                chk("start_while_done", 32'(gcd_done), 0);
                chk("issue_pending", 32'(iss_q.size() != 0), 1);
                if (iss_q.size() != 0) begin
                    e = iss_q.pop_front();
                    chk("gcd_a", 32'(gcd_a), 32'(e.a));
                    chk("gcd_b", 32'(gcd_b), 32'(e.b));
                end
            end
            if (hold_prev) begin
                chk("hold_valid", 32'(out_valid), 1);
                chk("hold_a", 32'(out_a), 32'(held.a));
                chk("hold_b", 32'(out_b), 32'(held.b));
                chk("hold_gcd", 32'(out_gcd), 32'(held.g));
                chk("hold_err", 32'(out_err), 32'(held.err));
            end
            hold_prev = out_valid && !out_ready;
            held = '{a: out_a, b: out_b, g: out_gcd, err: out_err};
            if (out_valid && out_ready) begin
                chk("sb_nonempty", 32'(sb_q.size() != 0), 1);
                chk("jobs_done", 32'(jobs_done), 32'(16'(exp_jobs)));
                exp_jobs++;
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    chk("out_a", 32'(out_a), 32'(e.a));
                    chk("out_b", 32'(out_b), 32'(e.b));
                    chk("out_gcd", 32'(out_gcd), 32'(e.g));
                    chk("out_err", 32'(out_err), 32'(e.err));
                end
            end
        end else begin
            hold_prev = 1'b0;
        end
    end

    // Entered and left at posedge+1
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] a, input logic [15:0] b, input logic err,
                        output int stalls);
        job_t j;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        stalls   = 0;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                j.a   = a;
                j.b   = b;
                j.g   = err ? 16'd0 : ref_gcd(a, b);
                j.err = err;
                sb_q.push_back(j);
                iss_q.push_back(j);
                break;
            end
            stalls++;
            if (stalls > 5000) begin
                chk("push_stall", 32'(stalls), 0);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((sb_q.size() != 0 || busy) && n < budget) begin
            step(1);
            n++;
        end
        chk("drain_left", 32'(sb_q.size()), 0);
        chk("drain_busy", 32'(busy), 0);
    endtask

    task automatic wait_ov(input int budget);
        int n = 0;
        while (!out_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("ov_wait", 32'(out_valid), 1);
    endtask

    logic [15:0] va[4];
    logic [15:0] vb[4];

    initial begin
        int st;
        int s0;
        int j0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;
        rst_n     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_err", 32'(out_err), 0);
        chk("rst_gcd_start", 32'(gcd_start), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_jobs_done", 32'(jobs_done), 0);
        chk("rst_out_a", 32'(out_a), 0);
        chk("rst_out_b", 32'(out_b), 0);
        chk("rst_out_gcd", 32'(out_gcd), 0);
        chk("rst_gcd_a", 32'(gcd_a), 0);
        chk("rst_gcd_b", 32'(gcd_b), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1);

        // Zero operand
        push(16'd0, 16'd36, 1'b0, st);
        drain(500);

        // Back-to-back jobs
        va = '{16'd111, 16'd11, 16'd37, 16'd65};
        vb = '{16'd0,   16'd11, 16'd75, 16'd25};
        for (int i = 0; i < 4; i++) begin
            push(va[i], vb[i], 1'b0, st);
            chk("b2b_stall", 32'(st), 0);
        end
        drain(500);

        // Output backpressure
        rdy_mode = 2;
        step(2);
        j0 = int'(jobs_done);
        push(16'd65, 16'd25, 1'b0, st);
        wait_ov(200);
        s0 = n_starts;
        repeat (20) @(negedge clk);
        chk("bp_valid", 32'(out_valid), 1);
        chk("bp_gcd", 32'(out_gcd), 5);
        chk("bp_starts", 32'(n_starts - s0), 0);
        chk("bp_jobs", 32'(jobs_done), 32'(j0));
        step(1);
        rdy_mode = 0;
        drain(100);
        chk("bp_jobs_inc", 32'(jobs_done), 32'(16'(j0 + 1)));

        // FIFO full with a stalled core
        core_hold = 1'b1;
        s0 = n_starts;
        for (int i = 0; i < 5; i++) begin
            push(16'(3 * (i + 1)), 16'(6 * (i + 2)), 1'b0, st);
            chk("fill_stall", 32'(st), 0);
        end
        in_valid = 1'b1;
        in_a     = 16'd999;
        in_b     = 16'd333;
        @(negedge clk);
        chk("full_in_ready", 32'(in_ready), 0);
        chk("full_busy", 32'(busy), 1);
        chk("full_one_start", 32'(n_starts - s0), 1);
        step(1);
        in_valid = 1'b0;
        step(3);
        core_hold = 1'b0;
        drain(500);

        // Randomized traffic
        rdy_mode = 1;
        lat_max  = 6;
        for (int i = 0; i < 150; i++) begin
            logic [15:0] a;
            logic [15:0] b;
            int          k;
            case ($urandom_range(0, 3))
                0: begin a = 16'($urandom_range(0, 1) * $urandom_range(0, 500)); b = 16'($urandom_range(0, 500)); end
                1: begin a = 16'($urandom_range(0, 100)); b = 16'($urandom_range(0, 100)); end
                2: begin k = int'($urandom_range(1, 60)); a = 16'(k * int'($urandom_range(1, 500))); b = 16'(k * int'($urandom_range(1, 500))); end
                default: begin a = 16'($urandom); b = 16'($urandom); end
            endcase
            if ($urandom_range(0, 3) == 0) step(int'($urandom_range(1, 4)));
            push(a, b, 1'b0, st);
        end
        drain(20000);
        rdy_mode = 0;
        lat_max  = 3;
        step(2);

`ifdef GCD_DISP_TIMEOUT_EN
        // Timeout abort, then a normal job
        begin
            int t0;
            int t1;
            int n;
            core_hold = 1'b1;
            push(16'd48, 16'd18, 1'b1, st);
            n = 0;
            while (!gcd_start && n < 50) begin @(negedge clk); n++; end
            t0 = cyc;
            wait_ov(1500);
            t1 = cyc;
            chk("tmo_latency", 32'(t1 - t0), 1025);
            chk("tmo_err", 32'(out_err), 1);
            step(1);
            core_kill = 1'b1;
            step(1);
            core_kill = 1'b0;
            core_hold = 1'b0;
            drain(100);
            push(16'd48, 16'd18, 1'b0, st);
            drain(200);
        end
`endif

        // Reset mid-job with jobs queued
        core_hold = 1'b1;
        for (int i = 0; i < 3; i++) push(16'(10 + i), 16'(20 + i), 1'b0, st);
        step(4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_out_valid", 32'(out_valid), 0);
        chk("mr_in_ready", 32'(in_ready), 1);
        chk("mr_busy", 32'(busy), 0);
        chk("mr_gcd_start", 32'(gcd_start), 0);
        chk("mr_jobs_done", 32'(jobs_done), 0);
        chk("mr_gcd_a", 32'(gcd_a), 0);
        chk("mr_out_a", 32'(out_a), 0);
        chk("mr_out_gcd", 32'(out_gcd), 0);
        sb_q.delete();
        iss_q.delete();
        exp_jobs  = 0;
        core_hold = 1'b0;
        step(2);
        @(negedge clk);
        rst_n = 1'b1;
        step(1);
        push(16'd65, 16'd25, 1'b0, st);
        drain(200);
        step(10);
        chk("final_jobs_done", 32'(jobs_done), 1);
        chk("final_out_valid", 32'(out_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gcd_dispatcher.md
# gcd_dispatcher

Initiator for the GCD core's start/done protocol. It accepts operand pairs on a valid/ready input, buffers them in a small FIFO, and issues them one at a time to an external `Greatest_Common_Divisor` core. It waits for the core's `done`, captures the result, and presents operands plus result on a valid/ready output. It sits between the host-side job source and the GCD core, replacing hand-driven start pulses.

## Interface
- `WIDTH`, 16: operand/result width; must match the GCD core.
- `DEPTH`, 4: operand FIFO entries; power of 2, ≥2.
- `TIMEOUT`, 1024: cycles allowed in WAIT_DONE before abort; used only with `GCD_DISP_TIMEOUT_EN`.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  FIFO not full.
- `in_a`, `in_b`  in  WIDTH  operands.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.
- `out_a`, `out_b`  out  WIDTH  operands of the presented job.
- `out_gcd`  out  WIDTH  result.
- `out_err`  out  1  job aborted by timeout.
- `gcd_start`  out  1  one-cycle start pulse to the core.
- `gcd_a`, `gcd_b`  out  WIDTH  operands to the core.
- `gcd_done`  in  1  core done level.
- `gcd_result`  in  WIDTH  core result.
- `busy`  out  1  state ≠ IDLE or FIFO non-empty.
- `jobs_done`  out  16  count of results handed off; wraps at 65535→0.

## Operation
- **Input push:** occurs when `in_valid & in_ready`. `in_ready = !full`, combinational from the registered count. A push while full is never taken, even if a pop occurs in the same cycle.
- **FSM states:** IDLE, ISSUE, WAIT_DONE, WAIT_CLR, OUTPUT.
  - **IDLE:** if FIFO non-empty, pop the head, load `gcd_a`/`gcd_b` and the `out_a`/`out_b` shadows, then go to ISSUE. Otherwise stay.
  - **ISSUE:** `gcd_start=1` for this single cycle. Go to WAIT_DONE.
  - **WAIT_DONE:** on the first cycle `gcd_done==1`, register `gcd_result` into `out_gcd`, clear `out_err`, and go to WAIT_CLR.
  - **WAIT_CLR:** wait until `gcd_done==0`, then go to OUTPUT. This guarantees the next start never overlaps the previous done.
  - **OUTPUT:** `out_valid=1`. On `out_ready`, increment `jobs_done` and go to IDLE.
- `gcd_done` is ignored outside WAIT_DONE and WAIT_CLR. This includes a stale high level during ISSUE.
- `gcd_a`/`gcd_b` hold stable from the pop until the next pop.
- `out_*` hold stable while `out_valid` is high and `out_ready` is low.
- Operand values of 0 are passed through unchanged. Their result semantics belong to the core.

## Timing
- **Reset values:** `in_ready=1`, `out_valid=0`, `out_err=0`, `gcd_start=0`, `busy=0`, `jobs_done=0`, and all data outputs 0. FIFO is empty and the FSM is in IDLE.
- **Issue latency:** a pair pushed into an empty idle block at edge k is popped at edge k+1. `gcd_start` is high from edge k+1 to edge k+2.
- **Output latency:** `out_valid` rises 1 cycle after the cycle in which `gcd_done` is first seen low in WAIT_CLR.
- **Minimum job period:** 5 cycles plus core compute time plus the core's done-high duration.
- **Reset mid-operation:** asserting `rst_n` low at any state returns to reset values immediately. Any in-flight job and all FIFO contents are discarded, and no output is produced for them.
- **Simultaneous push and pop (not full):** both take effect and the count is unchanged.

## Configuration
- **`GCD_DISP_TIMEOUT_EN` defined:**
  - A cycle counter runs in WAIT_DONE.
  - If it reaches `TIMEOUT` without `gcd_done`, go directly to OUTPUT with `out_err=1` and `out_gcd=0`.
  - WAIT_CLR is skipped in this case.
  - The counter clears on every entry to WAIT_DONE.
- **Not defined:** WAIT_DONE waits indefinitely, `out_err` is tied 0, and no counter logic is present.

## Test plan
- **Basic zero operand:** push (0,36) with `out_ready=1` against the real core → one `gcd_start` pulse, then `out_gcd=36`, `out_a=0`, `out_b=36`, `out_err=0`, `jobs_done=1`.
- **Back-to-back jobs:** push (111,0), (11,11), (37,75), (65,25) on consecutive cycles → `in_ready` stays 1 (depth 4). Results 111, 11, 1, 5 appear in order, and `gcd_start` is never high while `gcd_done` is high.
- **FIFO full:** stub core holds `gcd_done=0`; push 5 pairs → 1 popped, 4 buffered, and `in_ready=0` on the 6th attempt. The 6th pair is not accepted.
- **Output backpressure:** hold `out_ready=0` for 20 cycles after (65,25) completes → `out_valid` and `out_gcd=5` stay stable, with no new `gcd_start`. Release → `jobs_done` increments once.
- **Timeout (macro defined, TIMEOUT=1024):** stub core never asserts done → `out_valid` rises 1025 cycles after `gcd_start` with `out_err=1` and `out_gcd=0`. The next job then proceeds normally.
- **Reset mid-job:** drop `rst_n` during WAIT_DONE with 2 jobs queued → all outputs return to reset values asynchronously and no result appears. After release, a new (65,25) returns 5.
